// File: rtl/bus_pkg.sv
// rtl/bus_pkg.sv - shared encodings and defaults for the round-robin bus arbiter
package bus_pkg;
  typedef enum logic {ST_IDLE = 1'b0, ST_BUSY = 1'b1} state_e;

  localparam int N_DEF       = 8;
  localparam int IDW_DEF     = 3;
  localparam int TO_W_DEF    = 16;
  localparam int TIMEOUT_DEF = 1000;
endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - first set request bit in rotating order from start_i, optional masked index
module rr_pick #(
  parameter int N   = bus_pkg::N_DEF,
  parameter int IDW = bus_pkg::IDW_DEF
) (
  input  logic [N-1:0]   req_i,
  input  logic [IDW-1:0] start_i,
  input  logic           mask_en_i,
  input  logic [IDW-1:0] mask_idx_i,
  output logic           valid_o,
  output logic [IDW-1:0] idx_o
);
  logic [N-1:0] req_m;

  assign req_m = req_i & ~(mask_en_i ? (N'(1) << mask_idx_i) : '0);

  // Walk the order backwards so the last hit written is the first in rotating order.
  always_comb begin
    int pos;
    valid_o = 1'b0;
    idx_o   = '0;
    pos     = 0;
    for (int k = N - 1; k >= 0; k--) begin
      pos = (int'(start_i) + k) % N;
      if (req_m[pos[IDW-1:0]]) begin
        valid_o = 1'b1;
        idx_o   = pos[IDW-1:0];
      end
    end
  end
endmodule

// File: rtl/bus_arbiter_rr.sv
// rtl/bus_arbiter_rr.sv - round-robin DMA bus arbiter with grant hold and watchdog release
module bus_arbiter_rr
  import bus_pkg::*;
#(
  parameter int N       = N_DEF,
  parameter int IDW     = IDW_DEF,
  parameter int TO_W    = TO_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   dma,
  input  logic           ready,
  output logic [N-1:0]   grant,
  output logic           req,
  output logic [IDW-1:0] owner,
  output logic           timeout,
  output logic [IDW-1:0] timeout_id
);
  localparam bit            TO_EN   = (TIMEOUT != 0);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  state_e          state_q, state_d;
  logic [N-1:0]    grant_q, grant_d;
  logic [IDW-1:0]  owner_q, owner_d;
  logic [IDW-1:0]  ptr_q, ptr_d;
  logic [TO_W-1:0] timer_q, timer_d;
  logic            timeout_q, timeout_d;
  logic [IDW-1:0]  timeout_id_q, timeout_id_d;

  logic [IDW-1:0]  nxt_ptr;
  logic [IDW-1:0]  pick_start;
  logic            pick_valid;
  logic [IDW-1:0]  pick_idx;

  // Explicit wrap so non-power-of-two N never points past the last master.
  assign nxt_ptr    = (owner_q == IDW'(N - 1)) ? '0 : owner_q + 1'b1;
  assign pick_start = (state_q == ST_BUSY) ? nxt_ptr : ptr_q;

  rr_pick #(.N(N), .IDW(IDW)) u_pick (
    .req_i      (dma),
    .start_i    (pick_start),
    .mask_en_i  (state_q == ST_BUSY),
    .mask_idx_i (owner_q),
    .valid_o    (pick_valid),
    .idx_o      (pick_idx)
  );

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    owner_d      = owner_q;
    ptr_d        = ptr_q;
    timer_d      = timer_q;
    timeout_d    = 1'b0;
    timeout_id_d = timeout_id_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          grant_d = N'(1) << pick_idx;
          owner_d = pick_idx;
          timer_d = '0;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (ready) begin
          ptr_d = nxt_ptr;
          if (pick_valid) begin
            grant_d = N'(1) << pick_idx;
            owner_d = pick_idx;
            timer_d = '0;
          end else begin
            grant_d = '0;
            owner_d = '0;
            state_d = ST_IDLE;
          end
        end else if (!dma[owner_q]) begin
          grant_d = '0;
          owner_d = '0;
          ptr_d   = nxt_ptr;
          state_d = ST_IDLE;
        end else if (TO_EN && timer_q == TO_LAST) begin
          timeout_d    = 1'b1;
          timeout_id_d = owner_q;
          grant_d      = '0;
          owner_d      = '0;
          ptr_d        = nxt_ptr;
          state_d      = ST_IDLE;
        end else if (timer_q != '1) begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      grant_q      <= '0;
      owner_q      <= '0;
      ptr_q        <= '0;
      timer_q      <= '0;
      timeout_q    <= 1'b0;
      timeout_id_q <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      owner_q      <= owner_d;
      ptr_q        <= ptr_d;
      timer_q      <= timer_d;
      timeout_q    <= timeout_d;
      timeout_id_q <= timeout_id_d;
    end
  end

  assign grant      = grant_q;
  assign req        = |grant_q;
  assign owner      = owner_q;
  assign timeout    = timeout_q;
  assign timeout_id = timeout_id_q;
endmodule

// File: tb/tb_bus_arbiter_rr.sv
// tb/tb_bus_arbiter_rr.sv - scoreboard bench for bus_arbiter_rr with directed vectors
module tb_bus_arbiter_rr;
  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] dma;
  logic       ready;
  logic [7:0] grant;
  logic       req;
  logic [2:0] owner;
  logic       timeout;
  logic [2:0] timeout_id;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    int         cyc;
    logic [7:0] grant;
    logic [2:0] owner;
    logic       to;
    logic [2:0] tid;
    string      name;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;

  bus_arbiter_rr #(.N(8), .IDW(3), .TO_W(16), .TIMEOUT(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .dma        (dma),
    .ready      (ready),
    .grant      (grant),
    .req        (req),
    .owner      (owner),
    .timeout    (timeout),
    .timeout_id (timeout_id)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      cur = exp_q.pop_front();
      total++;
      if (cur.cyc != cyc) begin
        bad++;
        $display("FAIL %s: stale entry cycle=%0d required cycle=%0d", cur.name, cyc, cur.cyc);
      end else if (grant !== cur.grant || owner !== cur.owner || req !== (|cur.grant) ||
                   timeout !== cur.to || timeout_id !== cur.tid) begin
        bad++;
        $display("FAIL %s: got grant=%h owner=%0d req=%b timeout=%b tid=%0d, required grant=%h owner=%0d req=%b timeout=%b tid=%0d",
                 cur.name, grant, owner, req, timeout, timeout_id,
                 cur.grant, cur.owner, |cur.grant, cur.to, cur.tid);
      end
    end
  end

  task automatic step(input logic r, input logic [7:0] d, input logic rdy,
                      input logic [7:0] eg, input logic [2:0] eo, input logic et,
                      input logic [2:0] eid, input string nm);
    exp_t e;
    rst   = r;
    dma   = d;
    ready = rdy;
    e.cyc   = cyc + 1;
    e.grant = eg;
    e.owner = eo;
    e.to    = et;
    e.tid   = eid;
    e.name  = nm;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    step(1, 8'h00, 0, 8'h00, 0, 0, 0, "rst0");
    step(1, 8'h00, 0, 8'h00, 0, 0, 0, "rst1");

    step(0, 8'h81, 0, 8'h01, 0, 0, 0, "t1_grant0");
    step(0, 8'h81, 1, 8'h80, 7, 0, 0, "t1_b2b7");
    step(0, 8'h80, 1, 8'h00, 0, 0, 0, "t1_idle");
    step(0, 8'h81, 0, 8'h01, 0, 0, 0, "t1_regrant0");

    for (int i = 1; i <= 8; i++)
      step(0, 8'hFF, 1, 8'h01 << (i % 8), 3'(i % 8), 0, 0, "t2_rotate");
    step(0, 8'h00, 0, 8'h00, 0, 0, 0, "t2_withdraw");

    step(0, 8'h04, 0, 8'h04, 2, 0, 0, "t3_grant2");
    for (int i = 0; i < 3; i++)
      step(0, 8'h04, 0, 8'h04, 2, 0, 0, "t3_hold");
    step(0, 8'h04, 0, 8'h00, 0, 1, 2, "t3_timeout");
    step(0, 8'h00, 0, 8'h00, 0, 0, 2, "t3_pulse_end");
    step(0, 8'h0F, 0, 8'h08, 3, 0, 2, "t3_ptr3");

    for (int i = 0; i < 3; i++)
      step(0, 8'h08, 0, 8'h08, 3, 0, 2, "t4_hold");
    step(0, 8'h08, 1, 8'h00, 0, 0, 2, "t4_complete");
    step(0, 8'h00, 0, 8'h00, 0, 0, 2, "t4_idle");

    step(0, 8'h20, 0, 8'h20, 5, 0, 2, "t5_grant5");
    step(0, 8'h01, 0, 8'h00, 0, 0, 2, "t5_withdraw");
    step(0, 8'h21, 0, 8'h01, 0, 0, 2, "t5_wrap0");
    step(0, 8'h21, 1, 8'h20, 5, 0, 2, "t5_b2b5");
    step(0, 8'h21, 0, 8'h20, 5, 0, 2, "t6_busy");

    step(1, 8'h21, 1, 8'h00, 0, 0, 0, "t6_rst");
    step(1, 8'h21, 1, 8'h00, 0, 0, 0, "t6_rst_hold");
    step(0, 8'h21, 1, 8'h01, 0, 0, 0, "t6_restart0");
    step(0, 8'h21, 1, 8'h20, 5, 0, 0, "t6_b2b5");
    step(0, 8'h00, 1, 8'h00, 0, 0, 0, "t6_done");
    step(0, 8'h00, 0, 8'h00, 0, 0, 0, "t6_idle");

    repeat (3) @(negedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: pending=%0d required=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
